// File: rtl/freq_to_tuning.sv
`default_nettype none
// freq_to_tuning: gated rising-edge counter that converts an oscillator frequency into a DDS phase-increment word.
// Optional exponential smoothing of the output word is enabled by defining FTW_SMOOTH_EN.
module freq_to_tuning #(
  parameter int GATE_LOG2    = 16,
  parameter int CNT_W        = 16,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] offset,
  output logic [31:0]      tuningWord,
  output logic             word_valid,
  output logic             overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;

  localparam logic [GATE_LOG2-1:0] GATE_LAST = '1;
  localparam logic [GATE_LOG2-1:0] GATE_ONE  = GATE_LOG2'(1);
  localparam logic [CNT_W-1:0]     CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);

  if (CNT_W > GATE_LOG2 || GATE_LOG2 > 32 || SMOOTH_SHIFT < 0 || SMOOTH_SHIFT > 32) begin : g_bad_params
    $error("freq_to_tuning: illegal parameter combination");
  end

  logic [1:0]           state;
  logic                 s1, s2, s3;
  logic [GATE_LOG2-1:0] gate_cnt;
  logic [CNT_W-1:0]     edge_cnt;
  logic                 sat_seen;

  logic                 edge_det;
  logic                 edge_lost;
  logic                 terminal;
  logic [CNT_W-1:0]     n_snap;
  logic [CNT_W-1:0]     d_val;
  logic [31:0]          w_val;
  logic [31:0]          next_word;

  assign edge_det  = s2 & ~s3;
  // An edge arriving while the counter is already full is lost: that is saturation.
  assign edge_lost = edge_det & (edge_cnt == CNT_MAX);
  assign terminal  = (state == COUNT) & enable & (gate_cnt == GATE_LAST);
  assign n_snap    = edge_lost ? CNT_MAX : edge_cnt + (edge_det ? CNT_ONE : '0);
  assign d_val     = (n_snap > offset) ? n_snap - offset : '0;
  assign w_val     = 32'(d_val) << (32 - GATE_LOG2);

`ifdef FTW_SMOOTH_EN
  logic               first_word;
  logic signed [32:0] diff;
  logic signed [32:0] step;

  assign diff      = $signed({1'b0, w_val}) - $signed({1'b0, tuningWord});
  assign step      = diff >>> SMOOTH_SHIFT;
  assign next_word = first_word ? w_val : tuningWord + 32'(step);

  // The first word of each measurement run loads directly instead of ramping from a stale value.
  always_ff @(posedge clock) begin
    if (reset) begin
      first_word <= 1'b1;
    end else if (state == ARM) begin
      first_word <= 1'b1;
    end else if (terminal) begin
      first_word <= 1'b0;
    end
  end
`else
  assign next_word = w_val;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat_seen   <= 1'b0;
      tuningWord <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      s1         <= sig_in;
      s2         <= s1;
      s3         <= s2;
      word_valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat_seen <= 1'b0;
          if (enable) state <= ARM;
        end
        ARM: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat_seen <= 1'b0;
          state    <= enable ? COUNT : IDLE;
        end
        COUNT: begin
          if (!enable) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat_seen <= 1'b0;
          end else if (terminal) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat_seen   <= 1'b0;
            tuningWord <= next_word;
            overflow   <= sat_seen | edge_lost;
            word_valid <= 1'b1;
          end else begin
            gate_cnt <= gate_cnt + GATE_ONE;
            if (edge_det && !edge_lost) edge_cnt <= edge_cnt + CNT_ONE;
            if (edge_lost) sat_seen <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_to_tuning.sv
`default_nettype none
// tb_freq_to_tuning: directed vectors at GATE_LOG2=8 against a CNT_W=8 and a CNT_W=4 instance.
module tb_freq_to_tuning;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable8, enable4;
  logic        sig8, sig4;
  logic [7:0]  offset8;
  logic [3:0]  offset4;
  logic [31:0] tw8, tw4;
  logic        wv8, wv4, ovf8, ovf4;

  int vectors     = 0;
  int miscompares = 0;
  int ph8, ph4, per8, per4;
  int n, pulses;

`ifdef FTW_SMOOTH_EN
  localparam logic [31:0] EXP_OFF4  = 32'h0F00_0000;
  localparam logic [31:0] EXP_STEP1 = 32'h1400_0000;
  localparam logic [31:0] EXP_STEP2 = 32'h1700_0000;
`else
  localparam logic [31:0] EXP_OFF4  = 32'h0C00_0000;
  localparam logic [31:0] EXP_STEP1 = 32'h2000_0000;
  localparam logic [31:0] EXP_STEP2 = 32'h2000_0000;
`endif

  always #5 clock = ~clock;

  freq_to_tuning #(.GATE_LOG2(8), .CNT_W(8), .SMOOTH_SHIFT(2)) dut8 (
    .clock(clock), .reset(reset), .enable(enable8), .sig_in(sig8), .offset(offset8),
    .tuningWord(tw8), .word_valid(wv8), .overflow(ovf8)
  );

  freq_to_tuning #(.GATE_LOG2(8), .CNT_W(4), .SMOOTH_SHIFT(2)) dut4 (
    .clock(clock), .reset(reset), .enable(enable4), .sig_in(sig4), .offset(offset4),
    .tuningWord(tw4), .word_valid(wv4), .overflow(ovf4)
  );

  function automatic logic wave(int ph, int per);
    return (per != 0) && ((ph % per) >= (per / 2));
  endfunction

  // Inputs set here are sampled at the coming posedge; outputs are observed 1 ns after it.
  task automatic tick();
    sig8 = wave(ph8, per8);
    sig4 = wave(ph4, per4);
    ph8++;
    ph4++;
    @(posedge clock);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse8(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!wv8 && cycles < 600);
  endtask

  task automatic rearm8(int per, logic [7:0] off);
    enable8 = 1'b0;
    per8    = 0;
    repeat (3) tick();
    offset8 = off;
    per8    = per;
    ph8     = 0;
    enable8 = 1'b1;
  endtask

  initial begin
    reset   = 1'b1;
    enable8 = 1'b1;
    enable4 = 1'b1;
    offset8 = 8'd0;
    offset4 = 4'd0;
    per8    = 16;
    per4    = 4;
    ph8     = 0;
    ph4     = 0;
    sig8    = 1'b0;
    sig4    = 1'b0;

    repeat (2) tick();
    check("reset_tw8", tw8, 32'h0);
    check("reset_wv8", 32'(wv8), 32'h0);
    check("reset_ovf8", 32'(ovf8), 32'h0);
    check("reset_tw4", tw4, 32'h0);

    reset = 1'b0;
    ph8   = 0;
    ph4   = 0;
    wait_pulse8(n);
    check("first_latency", n, 258);
    check("p16_tw8", tw8, 32'h1000_0000);
    check("p16_ovf8", 32'(ovf8), 32'h0);
    check("sat_wv4", 32'(wv4), 32'h1);
    check("sat_tw4", tw4, 32'h0F00_0000);
    check("sat_ovf4", 32'(ovf4), 32'h1);

    per4 = 32;
    ph4  = 0;
    tick();
    check("wv_one_cycle", 32'(wv8), 32'h0);
    wait_pulse8(n);
    check("pulse_interval", n + 1, 256);
    check("p16_tw8_repeat", tw8, 32'h1000_0000);
    check("p32_tw4", tw4, 32'h0800_0000);
    check("p32_ovf4", 32'(ovf4), 32'h0);

    offset8 = 8'd4;
    wait_pulse8(n);
    check("offset4_tw8", tw8, EXP_OFF4);

    rearm8(16, 8'd20);
    wait_pulse8(n);
    check("rearm_latency", n, 258);
    check("offset20_clamp", tw8, 32'h0);

    rearm8(16, 8'd0);
    wait_pulse8(n);
    check("step_first_tw8", tw8, 32'h1000_0000);
    per8 = 8;
    ph8  = 0;
    wait_pulse8(n);
    check("step1_tw8", tw8, EXP_STEP1);
    wait_pulse8(n);
    check("step2_tw8", tw8, EXP_STEP2);

    pulses = 0;
    repeat (100) begin
      tick();
      if (wv8) pulses++;
    end
    enable8 = 1'b0;
    repeat (50) begin
      tick();
      if (wv8) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    check("abort_hold_tw8", tw8, EXP_STEP2);

    ph8     = 0;
    enable8 = 1'b1;
    wait_pulse8(n);
    check("reenable_latency", n, 258);
    check("reenable_tw8", tw8, 32'h2000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
